wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
// - Writeback-stage consumer of the M->W pipeline register: selects final write data,
//   performs load byte/half extraction and sign/zero extension, writes the 32x32 GRF.
// - Provides two D-stage read ports with same-cycle write-through bypass.
// - Keeps a retire counter of committed register writes for bench/debug visibility.
// PARAMETERS
// - NREG    32   number of architectural registers (index width = 5)
// - DW      32   data width
// - CNT_W   32   width of retire counter (wraps modulo 2^CNT_W)
// PORTS
// - clk        in   1   single clock; all state updates on posedge clk
// - reset_n    in   1   reset is synchronous and active-low
// - RegWriteW  in   1   write enable from W register
// - WriteRegW  in   5   destination register index
// - MemtoRegW  in   2   write-data select: 0 ALU, 1 load data, 2 pc+8, 3 reserved (=ALU)
// - opcodeW    in   6   instruction opcode; chooses load extension
// - ALUoutW    in   32  ALU result; ALUoutW[1:0] is load byte offset
// - DMoutW     in   32  full aligned word read from DM
// - pcW        in   32  pc of W-stage instruction
// - A1, A2     in   5   read addresses (rs, rt from D stage)
// - RD1, RD2   out  32  read data
// - WDataW     out  32  final write data (forwarding source for E/M/D muxes)
// - retire_cnt out  CNT_W  count of committed non-$0 writes
// BEHAVIOUR
// - Write data (combinational): MemtoRegW=0/3 -> ALUoutW; =2 -> pcW+8; =1 -> ext(DMoutW).
// - Load extension by opcodeW, off=ALUoutW[1:0]:
//   lw 0x23 -> word; lb 0x20 -> sext byte[off]; lbu 0x24 -> zext byte[off];
//   lh 0x21 -> sext half[off[1]]; lhu 0x25 -> zext half[off[1]]; other opcode -> word.
//   byte[0]=DMoutW[7:0] (little-endian); off[0] ignored for halves.
// - Commit condition: reset_n=1 && RegWriteW=1 && WriteRegW!=0.
// - On commit, GRF[WriteRegW] <= WDataW at posedge clk; retire_cnt <= retire_cnt+1 (wraps).
// - $0 always reads 0; writes to $0 ignored and not counted.
// - Reads combinational: RDx = (Ax==0) ? 0 : (commit && Ax==WriteRegW) ? WDataW : GRF[Ax].
//   Bypass gives write-through; D stage sees W result in the same cycle, no extra stall.
// - Both read ports may hit the same register and the write simultaneously; both bypass.
// - Reset: while reset_n=0 at posedge clk, all GRF entries <= 0, retire_cnt <= 0; commits
//   suppressed. RD1/RD2 return stored (cleared after first reset edge) values; no bypass
//   while reset_n=0. Reset mid-stream discards the in-flight W write.
// - WDataW is valid every cycle regardless of RegWriteW (consumers qualify with RegWriteW).
// - Latency: write visible in GRF one posedge after commit; visible on RDx immediately via bypass.
// - No X propagation: unused/reserved encodings resolve as listed above.
// STRUCTURE
// - Shared package (mips_pkg): opcode constants (OP_LW/LB/LBU/LH/LHU), MemtoReg encodings
//   (WB_ALU=0, WB_MEM=1, WB_PC8=2), register-index width.
// - Sub-module load_ext (combinational): inputs opcode, off[1:0], word; output extended word.
// - Top holds GRF array, bypass compare, write-data mux, retire counter.
// TESTING
// - Reset: hold reset_n=0 two cycles after writes -> all RDx=0, retire_cnt=0.
// - ALU write: RegWriteW=1, WriteRegW=8, MemtoRegW=0, ALUoutW=0x12345678, A1=8 ->
//   RD1=0x12345678 same cycle (bypass), still after edge; retire_cnt=1.
// - Loads: DMoutW=0x80FF7F01; lb off=3 -> 0xFFFFFF80; lbu off=1 -> 0x0000007F;
//   lh off=2 -> 0xFFFF80FF; lhu off=0 -> 0x00007F01; lw -> 0x80FF7F01.
// - jal link: MemtoRegW=2, pcW=0x00003000, WriteRegW=31 -> GRF[31]=0x00003008.
// - $0: RegWriteW=1, WriteRegW=0, ALUoutW=0xDEADBEEF, A1=A2=0 -> RD1=RD2=0, retire_cnt unchanged.
// - Reset mid-op: commit to $9 with reset_n=0 in same cycle -> GRF[9]=0, no count; then
//   back-to-back writes $9=1,$9=2 with A1=A2=9 -> RD1=RD2 track 1 then 2 each cycle.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the writeback stage: load opcodes,
//               write-data select encodings and register index width.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Register index width (32 architectural registers)
    localparam int REG_AW = 5;

    // Load opcodes that select an extension mode
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;

    // Write-data select encodings; 3 is reserved and behaves like WB_ALU
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC8 = 2'd2;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
// Module      : load_ext
// Description : Load data extraction. Picks a byte or halfword out of an
//               aligned little-endian word and sign/zero extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] extWord
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte/half, then extend according to the opcode
    always_comb begin
        w_byte  = 8'h00;
        w_half  = off[1] ? word[31:16] : word[15:0];
        extWord = word;
        case (off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        case (opcode)
            OP_LB:   extWord = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  extWord = {24'h000000, w_byte};
            OP_LH:   extWord = {{16{w_half[15]}}, w_half};
            OP_LHU:  extWord = {16'h0000, w_half};
            default: extWord = word;   // lw and any non-load opcode pass the word
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Writeback stage and general register file. Selects final
//               write data, writes the GRF, provides two bypassed read ports
//               and counts committed register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import mips_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic [1:0]        MemtoRegW,
    input  logic [5:0]        opcodeW,
    input  logic [DW-1:0]     ALUoutW,
    input  logic [DW-1:0]     DMoutW,
    input  logic [DW-1:0]     pcW,
    input  logic [REG_AW-1:0] A1,
    input  logic [REG_AW-1:0] A2,
    output logic [DW-1:0]     RD1,
    output logic [DW-1:0]     RD2,
    output logic [DW-1:0]     WDataW,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [DW-1:0]    r_grf [NREG];
    logic [CNT_W-1:0] r_retireCnt;
    logic [DW-1:0]    w_loadData;
    logic             w_commit;

    load_ext u_loadExt (
        .opcode  (opcodeW),
        .off     (ALUoutW[1:0]),
        .word    (DMoutW),
        .extWord (w_loadData)
    );

    // A write commits only out of reset and never to $0
    assign w_commit = reset_n && RegWriteW && (WriteRegW != '0);

    // Final write data; the reserved select value falls back to the ALU result
    always_comb begin
        WDataW = ALUoutW;
        case (MemtoRegW)
            WB_MEM:  WDataW = w_loadData;
            WB_PC8:  WDataW = pcW + DW'(8);
            default: WDataW = ALUoutW;
        endcase
    end

    // GRF and retire counter: cleared on reset, updated on each commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_grf[i] <= '0;
            end
            r_retireCnt <= '0;
        end else if (w_commit) begin
            r_grf[WriteRegW] <= WDataW;
            r_retireCnt      <= r_retireCnt + CNT_W'(1);
        end
    end

    // Read port 1 with write-through bypass of the committing write
    always_comb begin
        RD1 = r_grf[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (w_commit && (A1 == WriteRegW)) begin
            RD1 = WDataW;
        end
    end

    // Read port 2 with write-through bypass of the committing write
    always_comb begin
        RD2 = r_grf[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (w_commit && (A2 == WriteRegW)) begin
            RD2 = WDataW;
        end
    end

    assign retire_cnt = r_retireCnt;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Expected values are
//               queued when stimulus is applied and compared when sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [1:0]  MemtoRegW;
    logic [5:0]  opcodeW;
    logic [31:0] ALUoutW;
    logic [31:0] DMoutW;
    logic [31:0] pcW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] WDataW;
    logic [31:0] retire_cnt;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t    expQ[$];
    logic [31:0] obsQ[$];
    int          nRun  = 0;
    int          nFail = 0;
    int          expCnt = 0;

    wb_regfile #(.NREG(32), .DW(32), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .RegWriteW  (RegWriteW),
        .WriteRegW  (WriteRegW),
        .MemtoRegW  (MemtoRegW),
        .opcodeW    (opcodeW),
        .ALUoutW    (ALUoutW),
        .DMoutW     (DMoutW),
        .pcW        (pcW),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .WDataW     (WDataW),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Apply a W-stage write request (inputs change on negedge, away from posedge)
    task automatic drive(input logic we, input logic [4:0] wr, input logic [1:0] mtr,
                         input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] pc);
        RegWriteW = we;
        WriteRegW = wr;
        MemtoRegW = mtr;
        opcodeW   = op;
        ALUoutW   = alu;
        DMoutW    = dm;
        pcW       = pc;
    endtask

    task automatic expect_val(input string name, input logic [31:0] v);
        sb_item_t it;
        it.name = name;
        it.val  = v;
        expQ.push_back(it);
    endtask

    task automatic test_reset;
        sb_item_t it;
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 2'd0, 6'h00, 32'h0, 32'h0, 32'h0);
        A1 = 5'd8;
        A2 = 5'd31;
        repeat (2) @(posedge clk);
        #2;
        expCnt = 0;
        expect_val("reset_rd1_r8", 32'h0);         obsQ.push_back(RD1);
        expect_val("reset_rd2_r31", 32'h0);        obsQ.push_back(RD2);
        expect_val("reset_retire_cnt", 32'h0);     obsQ.push_back(retire_cnt);
        @(negedge clk);
        reset_n = 1'b1;
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_alu_write;
        sb_item_t it;
        @(negedge clk);
        drive(1'b1, 5'd8, 2'd0, 6'h00, 32'h12345678, 32'h0, 32'h0);
        A1 = 5'd8;
        A2 = 5'd0;
        expCnt++;
        #2;
        expect_val("alu_bypass_rd1", 32'h12345678);  obsQ.push_back(RD1);
        expect_val("alu_rd2_r0", 32'h0);             obsQ.push_back(RD2);
        expect_val("alu_wdata", 32'h12345678);       obsQ.push_back(WDataW);
        @(negedge clk);
        RegWriteW = 1'b0;
        #2;
        expect_val("alu_stored_rd1", 32'h12345678);  obsQ.push_back(RD1);
        expect_val("alu_retire_cnt", expCnt);        obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_loads;
        sb_item_t    it;
        logic [5:0]  ops  [8] = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h21, 6'h24, 6'h0F};
        logic [1:0]  offs [8] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd3, 2'd2};
        logic [31:0] exps [8] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                                  32'h80FF7F01, 32'hFFFF80FF, 32'h00000080, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(10 + i), 2'd1, ops[i], {30'h04000000, offs[i]}, 32'h80FF7F01, 32'h0);
            A1 = 5'(10 + i);
            expCnt++;
            #2;
            expect_val($sformatf("load%0d_bypass", i), exps[i]);  obsQ.push_back(RD1);
            expect_val($sformatf("load%0d_wdata", i), exps[i]);   obsQ.push_back(WDataW);
        end
        @(negedge clk);
        RegWriteW = 1'b0;
        for (int i = 0; i < 8; i++) begin
            A2 = 5'(10 + i);
            #1;
            expect_val($sformatf("load%0d_stored", i), exps[i]);  obsQ.push_back(RD2);
        end
        expect_val("load_retire_cnt", expCnt);  obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_jal;
        sb_item_t it;
        @(negedge clk);
        drive(1'b1, 5'd31, 2'd2, 6'h03, 32'hAAAA5555, 32'h0, 32'h00003000);
        expCnt++;
        #2;
        expect_val("jal_wdata", 32'h00003008);  obsQ.push_back(WDataW);
        @(negedge clk);
        drive(1'b1, 5'd30, 2'd3, 6'h00, 32'hCAFEF00D, 32'h11111111, 32'h00004000);
        expCnt++;
        #2;
        expect_val("reserved_sel_wdata", 32'hCAFEF00D);  obsQ.push_back(WDataW);
        @(negedge clk);
        RegWriteW = 1'b0;
        A1 = 5'd31;
        A2 = 5'd30;
        #2;
        expect_val("jal_stored_r31", 32'h00003008);  obsQ.push_back(RD1);
        expect_val("reserved_stored_r30", 32'hCAFEF00D);  obsQ.push_back(RD2);
        expect_val("jal_retire_cnt", expCnt);  obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_zero_reg;
        sb_item_t it;
        @(negedge clk);
        drive(1'b1, 5'd0, 2'd0, 6'h00, 32'hDEADBEEF, 32'h0, 32'h0);
        A1 = 5'd0;
        A2 = 5'd0;
        #2;
        expect_val("zero_rd1", 32'h0);  obsQ.push_back(RD1);
        expect_val("zero_rd2", 32'h0);  obsQ.push_back(RD2);
        @(negedge clk);
        RegWriteW = 1'b0;
        #2;
        expect_val("zero_rd1_after", 32'h0);        obsQ.push_back(RD1);
        expect_val("zero_retire_cnt", expCnt);      obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_reset_midop;
        sb_item_t it;
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b1, 5'd9, 2'd0, 6'h00, 32'h00000055, 32'h0, 32'h0);
        A1 = 5'd9;
        A2 = 5'd9;
        #2;
        expect_val("midop_no_bypass", 32'h0);  obsQ.push_back(RD1);
        @(negedge clk);
        reset_n = 1'b1;
        RegWriteW = 1'b0;
        expCnt = 0;
        #2;
        expect_val("midop_r9_cleared", 32'h0);   obsQ.push_back(RD1);
        expect_val("midop_retire_cnt", expCnt);  obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    task automatic test_back_to_back;
        sb_item_t it;
        for (int v = 1; v <= 2; v++) begin
            @(negedge clk);
            drive(1'b1, 5'd9, 2'd0, 6'h00, 32'(v), 32'h0, 32'h0);
            A1 = 5'd9;
            A2 = 5'd9;
            expCnt++;
            #2;
            expect_val($sformatf("b2b%0d_rd1", v), 32'(v));  obsQ.push_back(RD1);
            expect_val($sformatf("b2b%0d_rd2", v), 32'(v));  obsQ.push_back(RD2);
        end
        @(negedge clk);
        RegWriteW = 1'b0;
        #2;
        expect_val("b2b_stored_rd1", 32'h2);    obsQ.push_back(RD1);
        expect_val("b2b_stored_rd2", 32'h2);    obsQ.push_back(RD2);
        expect_val("b2b_retire_cnt", expCnt);   obsQ.push_back(retire_cnt);
        while (expQ.size() > 0) begin
            it = expQ.pop_front();
            nRun++;
            if (obsQ[0] !== it.val) begin
                nFail++;
                $display("FAIL %s: got %h expected %h", it.name, obsQ[0], it.val);
            end
            void'(obsQ.pop_front());
        end
    endtask

    // Scenario sequence
    initial begin
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 2'd0, 6'h00, 32'h0, 32'h0, 32'h0);
        A1 = 5'd0;
        A2 = 5'd0;
        test_reset;
        test_alu_write;
        test_loads;
        test_jal;
        test_zero_reg;
        test_reset;
        test_reset_midop;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
